muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 16, 32, 64).
REQ-002 SHALL have parameter MUL_LATENCY, default 2, multiply pipeline depth in cycles (legal 1..4).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request valid; accepted only when busy=0.
REQ-006 funct3  input  3  RV M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-008 op_b  input  XLEN  rs2 operand (divisor / multiplier).
REQ-009 kill  input  1  abort current operation.
REQ-010 busy  output  1  operation in flight.
REQ-011 done  output  1  one-cycle pulse, result valid.
REQ-012 result  output  XLEN  result; held stable until next accepted start.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX, DONE; busy=1 in MUL, DIV, FIX.
REQ-014 IDLE/DONE + start=1 -> funct3, op_a, op_b latched; funct3[2]=0 -> MUL, else DIV.
REQ-015 start while busy=1 SHALL be ignored, with no latch and no effect.
REQ-016 DONE lasts one cycle, done=1, then IDLE unless start accepted in same cycle (back-to-back allowed).
REQ-017 MUL: 2*XLEN-bit product from sign-extended (XLEN+1)-bit operands; a signed for 000/001/010, b signed for 000/001 only.
REQ-018 MUL: DONE reached exactly MUL_LATENCY edges after acceptance edge.
REQ-019 MUL: 000 -> product[XLEN-1:0]; others -> product[2XLEN-1:XLEN].
REQ-020 DIV: magnitudes taken for signed ops; restoring radix-2, one quotient bit per cycle, XLEN cycles in DIV, one cycle in FIX.
REQ-021 FIX: signed quotient negated iff signs differ; signed remainder takes dividend sign.
REQ-022 Divide by zero: quotient all-ones, remainder = op_a (both signed and unsigned).
REQ-023 Signed overflow (op_a = most-negative, op_b = -1): quotient = op_a, remainder = 0.
REQ-024 Nominal division DONE reached XLEN+1 edges after acceptance edge (special cases included unless REQ-030).
REQ-025 kill=1 in any busy state -> IDLE next edge, no done, result unchanged; kill has priority over start.
REQ-026 kill in IDLE/DONE SHALL have no effect; done pulse of DONE still emitted.
REQ-027 No combinational path from inputs to busy, done or result.

Reset
REQ-028 rst=1 SHALL force, asynchronously, state IDLE, busy=0, done=0, result=0, internal operand/accumulator registers=0.
REQ-029 rst asserted mid-operation SHALL discard the operation; first start after rst release accepted normally.

Configuration
REQ-030 Macro MULDIV_EARLY_OUT_EN defined: divide-by-zero and signed-overflow cases go straight to DONE one edge after acceptance, skipping DIV/FIX.
REQ-031 MULDIV_EARLY_OUT_EN undefined: special cases take full XLEN+1 latency, results per REQ-022/023.

Verification
REQ-032 XLEN=32, MUL_LATENCY=2: MULH a=0x80000000, b=0x80000000 -> done 2 edges after accept, result 0x40000000.
REQ-033 MULHSU a=0xFFFFFFFF (-1), b=0xFFFFFFFF (unsigned) -> result 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
REQ-034 DIV a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFD after 33 edges; REM same operands -> 0xFFFFFFFF.
REQ-035 DIVU a=5, b=0 -> 0xFFFFFFFF, REMU -> 5; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; latency 1 with MULDIV_EARLY_OUT_EN, 33 without.
REQ-036 DIVU started, kill at edge 10 -> busy=0 next edge, no done, result unchanged; start pulsed at edge 5 of a DIV is ignored.
REQ-037 rst raised mid-DIV -> busy, done, result at 0 immediately; MUL 3*4 after release -> result 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32/64 M-extension multiply/divide unit: pipelined multiply, restoring radix-2 divide.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish without iterating.
module muldiv_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            accept, early_out;
    logic [XLEN-1:0] a_mag_in, b_mag;
    logic [2*XLEN-1:0] ma_ext, mb_ext, prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   rem_shift, diff;
    logic            div_signed, b_zero, div_ovf;
    logic [XLEN-1:0] q_fix, r_fix, div_res;

    assign accept = start && (state_q == StIdle || state_q == StDone);

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = funct3[2] &&
                       (op_b == '0 || (!funct3[0] && op_a == MinNeg && op_b == '1));
`else
    assign early_out = 1'b0;
`endif

    // Dividend magnitude loaded straight into the quotient shift register.
    assign a_mag_in = (!funct3[0] && op_a[XLEN-1]) ? -op_a : op_a;

    // Multiply: sign/zero extension decides MUL/MULH/MULHSU/MULHU.
    always_comb begin
        ma_ext = {{XLEN{(funct3_q != 2'b11) && a_q[XLEN-1]}}, a_q};
        mb_ext = {{XLEN{!funct3_q[1] && b_q[XLEN-1]}}, b_q};
        prod   = ma_ext * mb_ext;
        mul_res = (funct3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Divide: one restoring step per cycle and the final sign fix-up.
    always_comb begin
        div_signed = !funct3_q[0];
        b_mag      = (div_signed && b_q[XLEN-1]) ? -b_q : b_q;
        rem_shift  = {rem_q, quo_q[XLEN-1]};
        diff       = rem_shift - {1'b0, b_mag};
        b_zero     = (b_q == '0);
        div_ovf    = div_signed && (a_q == MinNeg) && (b_q == '1);
        q_fix      = (div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo_q : quo_q;
        r_fix      = (div_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
        if (b_zero) begin
            q_fix = '1;
            r_fix = a_q;
        end else if (div_ovf) begin
            q_fix = a_q;
            r_fix = '0;
        end
        div_res = funct3_q[1] ? r_fix : q_fix;
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    funct3_d = funct3[1:0];
                    a_d      = op_a;
                    b_d      = op_b;
                    quo_d    = a_mag_in;
                    rem_d    = '0;
                    cnt_d    = '0;
                    if (!funct3[2]) begin
                        state_d = StMul;
                    end else if (early_out) begin
                        // FIX already resolves special cases; skip the iterations.
                        state_d = StFix;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                if (kill) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(MUL_LATENCY - 1)) begin
                    result_d = mul_res;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDiv: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
                    rem_d = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFix: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    result_d = div_res;
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    assign done   = (state_q == StDone);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: fixed vectors, corner sequences, random vs. model.
module tb_muldiv_unit;

    localparam int MulLat = 2;
    localparam int DivLat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SpLat = 1;
`else
    localparam int SpLat = 33;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_pass  = 0;
    int n_total = 0;

    muldiv_unit #(
        .XLEN        (32),
        .MUL_LATENCY (MulLat)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic following the RISC-V M rules.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [127:0] pa, pb, prod;
        longint       sa, sb, q, r;
        logic [63:0]  qv, rv;
        if (!f3[2]) begin
            pa   = (f3 != 3'b011) ? {{96{a[31]}}, a} : {96'b0, a};
            pb   = (f3[1] == 1'b0) ? {{96{b[31]}}, b} : {96'b0, b};
            prod = pa * pb;
            return (f3 == 3'b000) ? prod[31:0] : prod[63:32];
        end
        sa = !f3[0] ? longint'($signed(a)) : longint'({32'b0, a});
        sb = !f3[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (b == 32'b0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        qv = q;
        rv = r;
        return f3[1] ? rv[31:0] : qv[31:0];
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f3[2]) return MulLat;
        if (b == 32'b0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return SpLat;
        return DivLat;
    endfunction

    // Issue one op (from IDLE or DONE), count edges from acceptance until done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic kill_acc, output logic [31:0] res, output int lat);
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        kill   = kill_acc;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] res, prev, ea, eb;
        logic [2:0]  ef3;
        int          lat, cat;
        logic        seen;

        vecs[0]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat};
        vecs[3]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DivLat};
        vecs[4]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DivLat};
        vecs[5]  = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, SpLat};
        vecs[6]  = '{3'b111, 32'd5,         32'd0,         32'd5,         SpLat};
        vecs[7]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SpLat};
        vecs[8]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         SpLat};
        vecs[9]  = '{3'b000, 32'd3,         32'd4,         32'd12,        MulLat};
        vecs[10] = '{3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, SpLat};
        vecs[11] = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SpLat};
        vecs[12] = '{3'b000, 32'hFFFF_FFFF, 32'd7,         32'hFFFF_FFF9, MulLat};
        vecs[13] = '{3'b111, 32'hFFFF_FFF9, 32'd2,         32'd1,         DivLat};
        vecs[14] = '{3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, DivLat};

        rst    = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'b0;
        op_a   = 32'b0;
        op_b   = 32'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fixed vectors, issued back-to-back from the DONE cycle.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, 1'b0, res, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end
        @(posedge clk);
        #1;
        chk("done_single_pulse", done, 1'b0);
        chk("idle_not_busy", busy, 1'b0);

        // kill alongside start in IDLE does not block acceptance.
        run_op(3'b000, 32'd6, 32'd7, 1'b1, res, lat);
        chk("kill_idle_result", res, 32'd42);
        chk("kill_idle_latency", lat, MulLat);

        // start mid-DIV is ignored; original op completes.
        funct3 = 3'b100;
        op_a   = 32'd100;
        op_b   = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 4) begin
                start  = 1'b1;
                funct3 = 3'b000;
                op_a   = 32'd3;
                op_b   = 32'd4;
            end
            if (lat == 5) start = 1'b0;
        end
        chk("busy_start_ignored_result", result, 32'd14);
        chk("busy_start_ignored_latency", lat, DivLat);

        // Kill at edge 10 of a DIVU.
        @(posedge clk);
        #1;
        prev   = result;
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy", busy, 1'b0);
        chk("kill_done", done, 1'b0);
        chk("kill_result", result, prev);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("kill_no_done", seen, 1'b0);
        chk("kill_result_held", result, prev);

        // Asynchronous reset mid-DIV.
        funct3 = 3'b100;
        op_a   = 32'd50;
        op_b   = 32'd5;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_result", result, 32'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(3'b000, 32'd3, 32'd4, 1'b0, res, lat);
        chk("post_rst_mul_result", res, 32'd12);
        chk("post_rst_mul_latency", lat, MulLat);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            ef3 = 3'($urandom_range(0, 7));
            cat = $urandom_range(0, 5);
            ea  = $urandom;
            eb  = $urandom;
            if (cat == 0) begin
                eb = 32'b0;
            end else if (cat == 1) begin
                ea = 32'h8000_0000;
                eb = 32'hFFFF_FFFF;
            end else if (cat == 2) begin
                ea = 32'($signed(10'($urandom)));
                eb = 32'($signed(6'($urandom)));
            end
            run_op(ef3, ea, eb, 1'b0, res, lat);
            chk($sformatf("rand%0d_f%0d_%h_%h_result", i, ef3, ea, eb), res,
                ref_result(ef3, ea, eb));
            chk($sformatf("rand%0d_latency", i), lat, ref_latency(ef3, ea, eb));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
                chk($sformatf("rand%0d_done_pulse", i), done, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
